ins_fetch_mem: RTL
==================

Name: ins_fetch_mem

Overview:
- Parametrised instruction memory with a fetch handshake, replacing the bench's flat combinational instruction array.
- Sits between the processor's fetch port (ins_fetch_req/ins_pc) and a word-addressed program store.
- Adds configurable read latency, a program-load write port, a flush for branch redirects, and alignment/range fault reporting.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- DEPTH, 1024, number of instruction words; need not be a power of two.
- LATENCY, 1, request-to-data cycles; legal range 1..4.
- NOP_WORD, 32'h00000013, value driven on instruction when a fault is returned.

Ports:
- cpu_clock  in  1  clock; all state updates on the rising edge.
- cpu_reset_b  in  1  synchronous reset, active-high.
- ins_fetch_req  in  1  fetch request, qualified by ins_ready.
- ins_pc  in  32  byte address of the requested instruction.
- ins_ready  out  1  block accepts ins_fetch_req this cycle.
- flush  in  1  discard all in-flight fetches.
- instruction  out  DATA_WIDTH  returned instruction word.
- ins_valid  out  1  instruction/ins_fault valid this cycle; one-cycle pulse per accepted request.
- ins_fault  out  1  returned fetch faulted.
- ins_fault_code  out  2  0 = none, 1 = misaligned, 2 = out of range, 3 = both.
- ld_en  in  1  program-load write enable.
- ld_addr  in  $clog2(DEPTH)  word index to write.
- ld_data  in  DATA_WIDTH  word to write.

Behaviour:
- Reset outputs: ins_valid=0, ins_fault=0, ins_fault_code=0, instruction=NOP_WORD, ins_ready=1.
  - Reset clears the pipeline valid/tag registers, including any fetch in flight when reset asserts.
  - Reset does NOT clear memory contents.
- Accept rule: a fetch is accepted when ins_fetch_req && ins_ready at a rising edge.
- ins_ready = !ld_en (combinational). Load has priority; a fetch presented with ld_en is not accepted and must be held by the requester.
- Fault decode at acceptance:
  - misaligned if ins_pc[1:0] != 0;
  - out of range if ins_pc[31:2] >= DEPTH.
  - A faulting fetch performs no array read; it returns instruction=NOP_WORD with ins_fault=1 and the code.
- Read index: ins_pc[31:2], truncated to $clog2(DEPTH) bits only after the range check.
- Latency: a fetch accepted at edge N yields ins_valid=1 for exactly the cycle following edge N+LATENCY-1. Examples:
  - LATENCY=1: valid in the cycle after acceptance.
  - LATENCY=3: valid after the third edge.
- Pipeline shape:
  - Implement as a LATENCY-deep shift of {valid, fault_code}, plus the array read at stage 1 and data registers for stages 2..LATENCY.
  - Stages are fully pipelined: back-to-back fetches are accepted every cycle.
  - Responses return strictly in request order.
- Outputs while ins_valid=0: instruction holds its last value; ins_fault=0; ins_fault_code=0.
- Flush: at an edge with flush=1, every in-flight stage valid is cleared, so no response appears for those requests.
  - A fetch accepted in the same cycle as flush is NOT discarded; it returns after LATENCY cycles.
- Write/read same word: a load at edge N updates the array at N.
  - A fetch to that word accepted at a later edge returns the new data.
  - A same-edge fetch cannot occur, because ins_ready=0 while ld_en=1.
- Load address >= DEPTH: the write is ignored.
- No backpressure on the response side; the consumer must sink ins_valid every cycle.
- Parameter check: LATENCY outside 1..4 is a compile-time error (generate-time $error).

Test Plan:
- Program load, then streamed fetch:
  - Stimulus: reset 2 cycles, load words 0..3 = 11111111, 22222222, 33333333, 44444444, then fetch pc 0,4,8,C back-to-back with LATENCY=1.
  - Required: ins_valid high 4 consecutive cycles, data in order, ins_fault=0.
- Latency sweep:
  - Stimulus: repeat the previous scenario with LATENCY=3.
  - Required: first ins_valid exactly 3 cycles after the first accept edge, then 4 consecutive valids in order.
- Faults:
  - pc=0x6 -> ins_fault=1, code=1, instruction=00000013.
  - pc=4*DEPTH -> code=2.
  - pc=4*DEPTH+1 -> code=3.
  - A following pc=0 returns 11111111 with ins_fault=0.
- Flush:
  - Stimulus: LATENCY=3; accept pc 0,4; assert flush on the cycle pc 8 is accepted.
  - Required: only one ins_valid, carrying 33333333.
- Load priority and reset mid-operation:
  - Stimulus: ld_en=1 with ins_fetch_req=1 at pc=0 and ld_data=AAAAAAAA.
  - Required: ins_ready=0 and no accept that cycle; the next cycle's accepted fetch returns AAAAAAAA.
  - Stimulus: assert cpu_reset_b with 2 fetches in flight.
  - Required: no ins_valid afterwards; memory still reads AAAAAAAA at word 0.

Source files
------------

// File: rtl/ins_fetch_mem_if.sv
// Fetch/load bus between the processor fetch port and the instruction memory.
// Handshake: a fetch is accepted on a rising edge where ins_fetch_req && ins_ready;
// ins_valid is a one-cycle response pulse and is never backpressured.
interface ins_fetch_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  ins_fetch_req;
  logic [31:0]           ins_pc;
  logic                  ins_ready;
  logic                  flush;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  ins_valid;
  logic                  ins_fault;
  logic [1:0]            ins_fault_code;
  logic                  ld_en;
  logic [AW-1:0]         ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;

  modport master (
    output ins_fetch_req, ins_pc, flush, ld_en, ld_addr, ld_data,
    input  ins_ready, instruction, ins_valid, ins_fault, ins_fault_code
  );

  modport slave (
    input  ins_fetch_req, ins_pc, flush, ld_en, ld_addr, ld_data,
    output ins_ready, instruction, ins_valid, ins_fault, ins_fault_code
  );
endinterface

// File: rtl/ins_fetch_mem.sv
// Word-addressed instruction store with a LATENCY-deep fetch pipeline,
// program-load port, flush of in-flight fetches and alignment/range faults.
module ins_fetch_mem #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter int                    LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000013
) (
  input  logic          cpu_clock,
  input  logic          cpu_reset_b,
  ins_fetch_mem_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("ins_fetch_mem: LATENCY must be in 1..4");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [LATENCY-1:0]    valid_q;
  logic [1:0]            code_q [LATENCY];
  logic [DATA_WIDTH-1:0] data_q [LATENCY];

  logic          accept;
  logic [29:0]   word_idx;
  logic [1:0]    code_d;
  logic [AW-1:0] rd_idx;

  assign bus.ins_ready = !bus.ld_en;
  assign accept        = bus.ins_fetch_req && bus.ins_ready;
  assign word_idx      = bus.ins_pc[31:2];
  // Bit 1 = out of range, bit 0 = misaligned; range check uses the full word index.
  assign code_d        = {word_idx >= 30'(DEPTH), bus.ins_pc[1:0] != 2'b00};
  assign rd_idx        = word_idx[AW-1:0];

  always_ff @(posedge cpu_clock) begin
    if (bus.ld_en && ({1'b0, bus.ld_addr} < (AW+1)'(DEPTH))) begin
      mem_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (cpu_reset_b) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        code_q[i]  <= 2'b00;
        data_q[i]  <= NOP_WORD;
      end
    end else begin
      valid_q[0] <= accept;
      if (accept) begin
        code_q[0] <= code_d;
        data_q[0] <= (code_d == 2'b00) ? mem_q[rd_idx] : NOP_WORD;
      end
      // Data only advances with a surviving valid so the output holds between responses.
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1] && !bus.flush;
        if (valid_q[i-1] && !bus.flush) begin
          code_q[i] <= code_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign bus.ins_valid      = valid_q[LATENCY-1];
  assign bus.instruction    = data_q[LATENCY-1];
  assign bus.ins_fault_code = valid_q[LATENCY-1] ? code_q[LATENCY-1] : 2'b00;
  assign bus.ins_fault      = valid_q[LATENCY-1] && (code_q[LATENCY-1] != 2'b00);
endmodule
